// File: rtl/minute_tick_gen_pkg.sv
// Shared clock package: mode encodings, seconds-per-minute constant and the
// mode sequencing helper used by minute_tick_gen.
package minute_tick_gen_pkg;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_MIN  = 2'd1;
  localparam logic [1:0] MODE_SET_HOUR = 2'd2;

  localparam int SEC_PER_MIN = 60;
  localparam int SEC_W       = 6;

  typedef struct packed {
    logic mode;
    logic adv;
  } btn_press_t;

  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      MODE_RUN:     nxt = MODE_SET_MIN;
      MODE_SET_MIN: nxt = MODE_SET_HOUR;
      default:      nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/minute_tick_gen_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, optional debounce (BTN_DEBOUNCE_EN)
// and a registered rising-edge detector that emits a one-cycle press pulse.
module btn_conditioner #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       prev_q, prev_d;
  logic       press_q, press_d;
  logic       level;

`ifdef BTN_DEBOUNCE_EN
  localparam int DW = $clog2((DEB_CYCLES > 1) ? DEB_CYCLES : 2);
  localparam logic [DW-1:0] DEB_RELOAD = DW'(DEB_CYCLES - 1);

  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  // The level only moves after DEB_CYCLES consecutive samples disagree with it.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = DEB_RELOAD;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == '0) deb_d = sync2_q;
      else                 deb_cnt_d = deb_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign level = deb_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign level      = sync2_q;
`endif

  // armed_q blocks a press until a real low sample has been seen after reset,
  // so a button held through reset release stays silent until re-pressed.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
    prev_d  = level;
    press_d = level & ~prev_q & armed_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/minute_tick_gen.sv
// Seconds prescaler, RUN/SET_MIN/SET_HOUR mode FSM and minute/hour tick pulses
// for a clock display. Optional button debounce is enabled by BTN_DEBOUNCE_EN.
//
// state         | meaning
// MODE_RUN      | seconds count, minute tick on 59 -> 0, adv ignored
// MODE_SET_MIN  | seconds held, adv press pulses min_tick, display blinks
// MODE_SET_HOUR | seconds held, adv press pulses hour_tick, display blinks
module minute_tick_gen #(
  parameter int SEC_DIV    = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_adv,
  output logic       min_tick,
  output logic       hour_tick,
  output logic [5:0] sec_count,
  output logic [1:0] mode,
  output logic       blink
);
  import minute_tick_gen_pkg::*;

  localparam int PW = $clog2(SEC_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(SEC_DIV - 1);
  localparam logic [PW-1:0]    BLINK_TH   = PW'(SEC_DIV / 2);
  localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(SEC_PER_MIN - 1);

  btn_press_t press;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SEC_W-1:0] sec_count_q, sec_count_d;
  logic             min_tick_q, min_tick_d;
  logic             hour_tick_q, hour_tick_d;
  logic             blink_q, blink_d;

  logic sec_pulse;
  logic in_run;
  logic leave_set;
  logic adv_ok;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_mode (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_mode),
    .press   (press.mode)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_adv (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_adv),
    .press   (press.adv)
  );

  always_comb begin
    sec_pulse = (presc_q == PRESC_LAST);
    in_run    = (state_q == MODE_RUN);
    leave_set = press.mode && (state_q == MODE_SET_HOUR);
    // A simultaneous mode press takes priority over adv.
    adv_ok    = press.adv && !press.mode;

    state_d = press.mode ? next_mode(state_q) : state_q;

    presc_d = (sec_pulse || leave_set) ? '0 : presc_q + 1'b1;

    sec_count_d = sec_count_q;
    if (leave_set) begin
      sec_count_d = '0;
    end else if (in_run && sec_pulse) begin
      sec_count_d = (sec_count_q == SEC_LAST) ? '0 : sec_count_q + 1'b1;
    end

    // Self-gating on the registered pulse guarantees a low cycle between ticks.
    min_tick_d = ((in_run && sec_pulse && (sec_count_q == SEC_LAST)) ||
                  (adv_ok && (state_q == MODE_SET_MIN))) && !min_tick_q;
    hour_tick_d = adv_ok && (state_q == MODE_SET_HOUR) && !hour_tick_q;

    blink_d = (state_d != MODE_RUN) && (presc_d >= BLINK_TH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MODE_RUN;
      presc_q     <= '0;
      sec_count_q <= '0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_count_q <= sec_count_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
      blink_q     <= blink_d;
    end
  end

  assign min_tick  = min_tick_q;
  assign hour_tick = hour_tick_q;
  assign sec_count = sec_count_q;
  assign mode      = state_q;
  assign blink     = blink_q;

endmodule

// File: doc/minute_tick_gen.md
MINUTE_TICK_GEN -- requirements
Module: minute_tick_gen

Interface
REQ-001 SHALL have parameter SEC_DIV, default 50000000, giving clk cycles per second (minimum 2).
REQ-002 SHALL have parameter DEB_CYCLES, default 500000, giving the clk cycles a button must stay stable (used only with BTN_DEBOUNCE_EN).
REQ-003 SHALL have port clk, input, 1 bit: the board clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port btn_mode, input, 1 bit: raw, asynchronous mode push-button, active-high.
REQ-006 SHALL have port btn_adv, input, 1 bit: raw, asynchronous advance push-button, active-high.
REQ-007 SHALL have port min_tick, output, 1 bit: one-clk pulse that advances the minute counter downstream.
REQ-008 SHALL have port hour_tick, output, 1 bit: one-clk pulse that advances the hour counter downstream (set mode only).
REQ-009 SHALL have port sec_count, output, 6 bits: current second, 0..59.
REQ-010 SHALL have port mode, output, 2 bits: 0 = RUN, 1 = SET_MIN, 2 = SET_HOUR.
REQ-011 SHALL have port blink, output, 1 bit: display blink enable, at 50% duty in the set states.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer, then a registered rising-edge detector, producing a one-cycle press pulse.
REQ-013 SHALL run a prescaler that counts 0..SEC_DIV-1 and wraps in every state; sec_pulse SHALL be asserted in the cycle where the prescaler equals SEC_DIV-1.
REQ-014 In RUN, SHALL increment sec_count on each sec_pulse; at 59, sec_pulse SHALL wrap sec_count to 0 and assert min_tick on the next cycle, for exactly one cycle.
REQ-015 In the set states, SHALL hold sec_count and SHALL NOT assert min_tick from the prescaler.
REQ-016 FSM transitions on a mode press SHALL be RUN -> SET_MIN -> SET_HOUR -> RUN; with no press, the state SHALL be held.
REQ-017 On the transition SET_HOUR -> RUN, SHALL clear the prescaler and sec_count to 0 in the same cycle.
REQ-018 An adv press in SET_MIN SHALL assert min_tick for one cycle on the following cycle; an adv press in SET_HOUR SHALL assert hour_tick for one cycle on the following cycle; an adv press in RUN SHALL be ignored.
REQ-019 If mode and adv presses occur in the same cycle, the mode press SHALL win and the adv press SHALL be discarded.
REQ-020 min_tick and hour_tick SHALL never be high in the same cycle; each SHALL be low for at least one cycle between pulses.
REQ-021 blink SHALL be 0 in RUN; in the set states it SHALL be 1 while the prescaler is >= SEC_DIV/2 (integer division), else 0.
REQ-022 All outputs SHALL be registered.
REQ-023 Latency from a clean button rise to the output pulse SHALL be exactly 4 clk cycles without debounce.

Reset
REQ-024 Reset SHALL force state RUN, prescaler 0, sec_count 0, min_tick 0, hour_tick 0, blink 0, and all synchronizer, edge and debounce flops 0.
REQ-025 Reset asserted mid-set SHALL return the block to RUN; a button held through reset release SHALL NOT generate a press until it is released and pressed again.

Configuration
REQ-026 With BTN_DEBOUNCE_EN defined, each synchronized button SHALL update its debounced level only after DEB_CYCLES consecutive equal samples; edge detection SHALL use the debounced level, and latency becomes DEB_CYCLES+4.
REQ-027 With BTN_DEBOUNCE_EN undefined, the debounce logic SHALL be absent and edge detection SHALL use the synchronizer output directly.

Structure
REQ-028 The mode encodings (RUN, SET_MIN, SET_HOUR) and the constant SEC_PER_MIN = 60 SHALL live in the shared clock package.
REQ-029 Synchronizer, optional debounce and edge detect SHALL form one sub-module, btn_conditioner, instantiated once per button.

Verification (SEC_DIV=4, BTN_DEBOUNCE_EN undefined)
REQ-030 Release reset, RUN for 240 cycles -> sec_count wraps 59 -> 0 once, and min_tick is high for exactly 1 cycle, on cycle 241.
REQ-031 Press btn_mode once, then btn_adv 3 times -> mode = 1, and 3 separate min_tick pulses, each appearing 4 cycles after its btn_adv rise.
REQ-032 Press btn_mode twice, then btn_adv once -> mode = 2, one hour_tick, and min_tick stays 0.
REQ-033 Raise btn_mode and btn_adv in the same cycle from RUN -> mode = 1, with no min_tick and no hour_tick.
REQ-034 In SET_HOUR with sec_count = 17, press btn_mode -> mode = 0, sec_count = 0, and prescaler = 0 in the same cycle.
REQ-035 Assert reset while in SET_MIN holding btn_adv -> all outputs 0 and mode 0 after reset; no tick until btn_adv is released and pressed again.
